// File: rtl/axi4_lite_fanin_rd.sv
// Two-master to one-slave AXI4-lite read arbiter: round-robin AR grant,
// in-order source-index FIFO steering R beats back to the requester.
module axi4_lite_fanin_rd #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int D = 4,
  parameter int I = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // upstream requesters
  input  logic [1:0]             s_arvalid_i,
  output logic [1:0]             s_arready_o,
  input  logic [1:0][A-1:0]      s_araddr_i,
  input  logic [1:0][2:0]        s_arprot_i,
  input  logic [1:0][I-1:0]      s_arid_i,
  output logic [1:0]             s_rvalid_o,
  input  logic [1:0]             s_rready_i,
  output logic [1:0][8*N-1:0]    s_rdata_o,
  output logic [1:0][1:0]        s_rresp_o,
  output logic [1:0][I-1:0]      s_rid_o,
  output logic [1:0]             s_awready_o,
  output logic [1:0]             s_wready_o,
  output logic [1:0]             s_bvalid_o,
  // shared downstream port
  output logic                   m_arvalid_o,
  input  logic                   m_arready_i,
  output logic [A-1:0]           m_araddr_o,
  output logic [2:0]             m_arprot_o,
  output logic [I-1:0]           m_arid_o,
  input  logic                   m_rvalid_i,
  output logic                   m_rready_o,
  input  logic [8*N-1:0]         m_rdata_i,
  input  logic [1:0]             m_rresp_i,
  input  logic [I-1:0]           m_rid_i,
  output logic                   m_awvalid_o,
  output logic                   m_wvalid_o,
  output logic                   m_bready_o,
  // state visibility
  output logic [$clog2(D):0]     dbg_count_o,
  output logic                   dbg_lock_o,
  output logic                   dbg_last_grant_o
);

  // Handshake rule on every channel: a transfer happens on a rising aclk
  // edge where valid and ready are both high; a raised valid with its
  // payload is held until that edge.

  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;

  logic          sel_q, sel;
  logic          last_grant_q;
  logic          lock_q, lock_d;
  logic [D-1:0]  fifo_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, head;
  logic ar_valid, ar_hs, r_ready, r_hs;

  // Grant is frozen while a request is pending so the AR payload stays stable.
  always_comb begin
    sel = sel_q;
    if (!lock_q) begin
      case (s_arvalid_i)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~last_grant_q;
        default: sel = sel_q;
      endcase
    end
  end

  assign full     = (count_q == CW'(D));
  assign empty    = (count_q == '0);
  assign head     = fifo_q[rd_ptr_q];

  assign ar_valid = aresetn & s_arvalid_i[sel] & ~full;
  assign ar_hs    = ar_valid & m_arready_i;
  assign r_ready  = aresetn & s_rready_i[head] & ~empty;
  assign r_hs     = r_ready & m_rvalid_i;

  assign m_arvalid_o = ar_valid;
  assign m_araddr_o  = s_araddr_i[sel];
  assign m_arprot_o  = s_arprot_i[sel];
  assign m_arid_o    = s_arid_i[sel];
  assign m_rready_o  = r_ready;

  always_comb begin
    s_arready_o       = 2'b00;
    s_rvalid_o        = 2'b00;
    s_arready_o[sel]  = aresetn & m_arready_i & ~full;
    s_rvalid_o[head]  = aresetn & m_rvalid_i & ~empty;
  end

  // Read data is broadcast; only the source seeing rvalid consumes it.
  assign s_rdata_o[0] = m_rdata_i;
  assign s_rdata_o[1] = m_rdata_i;
  assign s_rresp_o[0] = m_rresp_i;
  assign s_rresp_o[1] = m_rresp_i;
  assign s_rid_o[0]   = m_rid_i;
  assign s_rid_o[1]   = m_rid_i;

  assign s_awready_o = 2'b00;
  assign s_wready_o  = 2'b00;
  assign s_bvalid_o  = 2'b00;
  assign m_awvalid_o = 1'b0;
  assign m_wvalid_o  = 1'b0;
  assign m_bready_o  = 1'b1;

  always_comb begin
    lock_d = lock_q;
    if (ar_hs)         lock_d = 1'b0;
    else if (ar_valid) lock_d = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({ar_hs, r_hs})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sel_q   <= sel;
      lock_q  <= lock_d;
      count_q <= count_d;
      if (ar_hs) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
        last_grant_q     <= sel;
      end
      if (r_hs) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign dbg_count_o      = count_q;
  assign dbg_lock_o       = lock_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_axi4_lite_fanin_rd.sv
// Directed bench for axi4_lite_fanin_rd (A=32, N=4, D=4): arbitration,
// stall hold, full gating, in-order R routing and reset behaviour.
module tb_axi4_lite_fanin_rd;

  localparam int A = 32;
  localparam int N = 4;
  localparam int D = 4;
  localparam int I = 1;

  logic aclk = 1'b0;
  logic aresetn;

  logic [1:0]          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]          s_awready, s_wready, s_bvalid;
  logic [1:0][A-1:0]   s_araddr;
  logic [1:0][2:0]     s_arprot;
  logic [1:0][I-1:0]   s_arid, s_rid;
  logic [1:0][8*N-1:0] s_rdata;
  logic [1:0][1:0]     s_rresp;
  logic                m_arvalid, m_arready, m_rvalid, m_rready;
  logic                m_awvalid, m_wvalid, m_bready;
  logic [A-1:0]        m_araddr;
  logic [2:0]          m_arprot;
  logic [I-1:0]        m_arid, m_rid;
  logic [8*N-1:0]      m_rdata;
  logic [1:0]          m_rresp;
  logic [2:0]          dbg_count;
  logic                dbg_lock, dbg_last_grant;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_fanin_rd #(.A(A), .N(N), .D(D), .I(I)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
    .s_arprot_i(s_arprot), .s_arid_i(s_arid),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata),
    .s_rresp_o(s_rresp), .s_rid_o(s_rid),
    .s_awready_o(s_awready), .s_wready_o(s_wready), .s_bvalid_o(s_bvalid),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_arprot_o(m_arprot), .m_arid_o(m_arid),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata),
    .m_rresp_i(m_rresp), .m_rid_i(m_rid),
    .m_awvalid_o(m_awvalid), .m_wvalid_o(m_wvalid), .m_bready_o(m_bready),
    .dbg_count_o(dbg_count), .dbg_lock_o(dbg_lock), .dbg_last_grant_o(dbg_last_grant)
  );

  // clock / reset block
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rid     = '0;
  endtask

  logic [5:0] push_src = 6'b011001;  // bit i = source of AR in cycle i: 1,0,0,1,1,0
  logic [5:0] exp_head = 6'b100110;  // bit i = expected R owner in cycle i: 0,1,1,0,0,1

  initial begin
    s_araddr = '0;
    s_arprot = '0;
    s_arid   = '0;
    idle();

    // reset with every input asserted: outputs must stay low
    aresetn   = 1'b0;
    s_arvalid = 2'b11;
    s_rready  = 2'b11;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    step();
    step();
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s_arready", s_arready, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_count", dbg_count, 0);
    chk("rst_last_grant", dbg_last_grant, 1);
    chk("tie_m_bready", m_bready, 1);
    chk("tie_writes", {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid}, 0);
    idle();
    aresetn = 1'b1;
    settle();
    chk("post_rst_lock", dbg_lock, 0);

    // single read from s0
    s_araddr[0] = 32'h10;
    s_arprot[0] = 3'b010;
    s_arvalid   = 2'b01;
    m_arready   = 1'b1;
    settle();
    chk("t1_araddr", m_araddr, 32'h10);
    chk("t1_arprot", m_arprot, 3'b010);
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_s_arready", s_arready, 2'b01);
    step();
    chk("t1_count1", dbg_count, 1);
    idle();
    m_rvalid = 1'b1;
    m_rdata  = 32'hA5;
    s_rready = 2'b11;
    settle();
    chk("t1_rvalid", s_rvalid, 2'b01);
    chk("t1_rdata0", s_rdata[0], 32'hA5);
    chk("t1_rready", m_rready, 1);
    step();
    chk("t1_count0", dbg_count, 0);
    idle();

    // short reset so that source 0 wins the first contested grant
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;

    // both requesting every cycle: grants 0,1,0,1
    s_araddr[0] = 32'h100;
    s_araddr[1] = 32'h200;
    s_arvalid   = 2'b11;
    m_arready   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_araddr", m_araddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("t2_s_arready", s_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    chk("t2_count_full", dbg_count, 4);
    idle();
    s_rready = 2'b11;
    m_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rdata = 32'(k + 1);
      settle();
      chk("t2_rvalid", s_rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    chk("t2_count0", dbg_count, 0);
    idle();

    // stall: s0 pending, s1 joins mid-stall, payload must hold
    s_araddr[0] = 32'h300;
    s_araddr[1] = 32'h400;
    s_arvalid   = 2'b01;
    m_arready   = 1'b0;
    settle();
    chk("t3_stall0_araddr", m_araddr, 32'h300);
    step();
    chk("t3_lock", dbg_lock, 1);
    s_arvalid = 2'b11;
    for (int k = 1; k < 3; k++) begin
      settle();
      chk("t3_stall_araddr", m_araddr, 32'h300);
      chk("t3_stall_arready", s_arready, 2'b00);
      step();
    end
    m_arready = 1'b1;
    settle();
    chk("t3_grant0_arready", s_arready, 2'b01);
    step();
    chk("t3_unlock", dbg_lock, 0);
    settle();
    chk("t3_grant1_araddr", m_araddr, 32'h400);
    chk("t3_grant1_arready", s_arready, 2'b10);
    step();
    chk("t3_count2", dbg_count, 2);
    idle();

    // concurrent AR and R handshakes at count 2 (FIFO holds 0,1)
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    s_rready  = 2'b11;
    for (int k = 0; k < 6; k++) begin
      s_arvalid = push_src[k] ? 2'b10 : 2'b01;
      m_rdata   = 32'h50 + 32'(k);
      settle();
      chk("t5_s_arready", s_arready, push_src[k] ? 2'b10 : 2'b01);
      chk("t5_rvalid", s_rvalid, exp_head[k] ? 2'b10 : 2'b01);
      chk("t5_rready", m_rready, 1);
      step();
      chk("t5_count", dbg_count, 2);
    end
    s_arvalid = 2'b00;
    settle();
    chk("t5_drain0", s_rvalid, 2'b10);
    step();
    chk("t5_drain1", s_rvalid, 2'b01);
    step();
    chk("t5_count0", dbg_count, 0);
    idle();

    // fill to D, fifth AR gated until one R beat retires
    s_araddr[1] = 32'h600;
    s_arvalid   = 2'b10;
    m_arready   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t4_fill_arready", s_arready, 2'b10);
      step();
    end
    chk("t4_count4", dbg_count, 4);
    chk("t4_full_arvalid", m_arvalid, 0);
    chk("t4_full_arready", s_arready, 2'b00);
    step();
    chk("t4_count_hold", dbg_count, 4);
    m_rvalid = 1'b1;
    s_rready = 2'b11;
    settle();
    chk("t4_full_arvalid2", m_arvalid, 0);
    chk("t4_r_to_s1", s_rvalid, 2'b10);
    step();
    m_rvalid = 1'b0;
    settle();
    chk("t4_count3", dbg_count, 3);
    chk("t4_fifth_arvalid", m_arvalid, 1);
    chk("t4_fifth_arready", s_arready, 2'b10);
    step();
    chk("t4_count4b", dbg_count, 4);
    s_arvalid = 2'b00;
    m_rvalid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t4_drain", s_rvalid, 2'b10);
      step();
    end
    chk("t4_count0", dbg_count, 0);
    settle();

    // stray R beat with nothing outstanding
    chk("t6_stray_rready", m_rready, 0);
    chk("t6_stray_rvalid", s_rvalid, 2'b00);
    idle();

    // reset in the middle of a burst
    s_araddr[0] = 32'h700;
    s_arvalid   = 2'b01;
    m_arready   = 1'b1;
    step();
    step();
    chk("t6_count2", dbg_count, 2);
    aresetn  = 1'b0;
    m_rvalid = 1'b1;
    s_rready = 2'b11;
    settle();
    chk("t6_rst_arvalid", m_arvalid, 0);
    chk("t6_rst_arready", s_arready, 2'b00);
    chk("t6_rst_rready", m_rready, 0);
    chk("t6_rst_rvalid", s_rvalid, 2'b00);
    step();
    chk("t6_rst_count", dbg_count, 0);
    aresetn   = 1'b1;
    s_arvalid = 2'b00;
    settle();
    chk("t6_post_rready", m_rready, 0);
    chk("t6_post_rvalid", s_rvalid, 2'b00);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
